color_write_arbiter: RTL and testbench

Arbitrates write access to the four-slot color register bank between two requesters, e.g. the switch-entry path and the serial-load path. Each requester presents a slot index and color word under a req/ack handshake. The block grants one request at a time with round-robin fairness and emits a single-cycle one-hot write enable plus write data to the bank. It replaces direct per-slot enable sequencing whenever more than one source can program colors.

---
 rtl/color_write_arbiter.sv | 100 ++++++++++
 tb/tb_color_write_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_write_arbiter.sv
// Round-robin write arbiter for the four-slot color register bank.
// Grants one requester at a time and issues a single-cycle one-hot write plus an ack.
module color_write_arbiter #(
  parameter int unsigned COLOR_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lock,
  input  logic               req0,
  input  logic [1:0]         idx0,
  input  logic [COLOR_W-1:0] data0,
  output logic               ack0,
  input  logic               req1,
  input  logic [1:0]         idx1,
  input  logic [COLOR_W-1:0] data1,
  output logic               ack1,
  output logic [3:0]         we,
  output logic [COLOR_W-1:0] wdata,
  output logic               busy,
  output logic [7:0]         wr_count
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e     state_q;
  logic       grant_q;
  logic       last_grant_q;
  logic [1:0] served_q;
  logic [1:0] served_d;
  logic [1:0] req_vec;
  logic [1:0] eligible;
  logic       grant_vld;
  logic       grant_sel;
  logic [1:0] grant_idx;

  assign req_vec  = {req1, req0};
  assign eligible = req_vec & ~served_q & {2{~lock}};

  always_comb begin
    grant_vld = |eligible;
    grant_sel = (eligible == 2'b11) ? ~last_grant_q : eligible[1];
    grant_idx = grant_sel ? idx1 : idx0;
  end

  // A served requester stays blocked only while its req is held high.
  always_comb begin
    served_d = served_q & req_vec;
    if (state_q == StDone) begin
      served_d[grant_q] = req_vec[grant_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      served_q     <= 2'b00;
      we           <= 4'b0000;
      wdata        <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy         <= 1'b0;
      wr_count     <= 8'd0;
    end else begin
      we       <= 4'b0000;
      wdata    <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      served_q <= served_d;
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            state_q <= StWrite;
            grant_q <= grant_sel;
            we      <= 4'b0001 << grant_idx;
            wdata   <= grant_sel ? data1 : data0;
            busy    <= 1'b1;
          end
        end
        StWrite: begin
          state_q <= StDone;
          ack0    <= ~grant_q;
          ack1    <= grant_q;
        end
        StDone: begin
          state_q      <= StIdle;
          busy         <= 1'b0;
          last_grant_q <= grant_q;
          wr_count     <= wr_count + 8'd1;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_write_arbiter.sv
// Bench for color_write_arbiter: transaction-timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_color_write_arbiter;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         lock = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [1:0]   idx0 = 2'd0;
  logic [1:0]   idx1 = 2'd0;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;
  logic         ack0, ack1, busy;
  logic [3:0]   we;
  logic [W-1:0] wdata;
  logic [7:0]   wr_count;

  always #5 clk = ~clk;

  color_write_arbiter #(.COLOR_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .lock     (lock),
    .req0     (req0),
    .idx0     (idx0),
    .data0    (data0),
    .ack0     (ack0),
    .req1     (req1),
    .idx1     (idx1),
    .data1    (data1),
    .ack1     (ack1),
    .we       (we),
    .wdata    (wdata),
    .busy     (busy),
    .wr_count (wr_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;
  int ack_log[$];

  // Model: an in-flight transaction is described by its age in edges since its grant.
  bit           m_active = 1'b0;
  int           m_age = 0;
  int           m_who = 0;
  logic [1:0]   m_idx = 2'd0;
  logic [W-1:0] m_data = '0;
  int           m_last = 1;
  bit [1:0]     m_served = 2'b00;
  int           m_count = 0;

  logic [3:0]   e_we;
  logic [W-1:0] e_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int k);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step(1);
      if (((k == 0) ? ack0 : ack1) === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: requester %0d got no ack, required one within 20 cycles", k);
    end
  endtask

  // Advance the model across the coming rising edge using the inputs it will sample.
  task automatic model_step();
    bit       done_now;
    bit [1:0] req_v;
    bit [1:0] elig;
    bit [1:0] new_served;
    int       who;
    if (reset) begin
      m_active = 1'b0;
      m_age    = 0;
      m_last   = 1;
      m_served = 2'b00;
      m_count  = 0;
    end else begin
      done_now   = m_active && (m_age == 1);
      req_v      = {req1, req0};
      elig       = req_v & ~m_served & {2{~lock}};
      new_served = req_v & (m_served | (done_now ? (2'b01 << m_who) : 2'b00));
      if (m_active) begin
        if (done_now) begin
          m_active = 1'b0;
          m_count  = (m_count + 1) % 256;
          m_last   = m_who;
        end else begin
          m_age++;
        end
      end else if (elig != 2'b00) begin
        who      = (elig == 2'b11) ? (1 - m_last) : (elig[1] ? 1 : 0);
        m_active = 1'b1;
        m_age    = 0;
        m_who    = who;
        m_idx    = (who == 1) ? idx1 : idx0;
        m_data   = (who == 1) ? data1 : data0;
      end
      m_served = new_served;
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      e_we    = (m_active && m_age == 0) ? (4'b0001 << m_idx) : 4'b0000;
      e_wdata = (m_active && m_age == 0) ? m_data : '0;
      check("model_we", we, e_we);
      check("model_wdata", wdata, e_wdata);
      check("model_ack0", ack0, m_active && m_age == 1 && m_who == 0);
      check("model_ack1", ack1, m_active && m_age == 1 && m_who == 1);
      check("model_busy", busy, m_active);
      check("model_wr_count", wr_count, m_count);
      if (ack0 === 1'b1) ack_log.push_back(0);
      if (ack1 === 1'b1) ack_log.push_back(1);
      model_step();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    step(1);
    checking = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_we", we, 4'b0000);
    check("rst_wdata", wdata, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_count", wr_count, 0);

    // Single write, req held afterwards
    idx0 = 2'd2; data0 = 24'hFF0000; req0 = 1'b1;
    step(1);
    check("single_we", we, 4'b0100);
    check("single_wdata", wdata, 32'h00FF0000);
    check("single_busy", busy, 1);
    step(1);
    check("single_we_off", we, 4'b0000);
    check("single_ack0", ack0, 1);
    step(1);
    check("single_ack0_off", ack0, 0);
    check("single_count", wr_count, 1);
    check("single_busy_off", busy, 0);
    step(6);
    check("single_no_repeat", wr_count, 1);
    req0 = 1'b0;
    step(1);

    // Tie after reset: requester 0 first
    do_reset();
    idx0 = 2'd0; data0 = 24'h00FF00; idx1 = 2'd3; data1 = 24'h0000FF;
    req0 = 1'b1; req1 = 1'b1;
    step(1);
    check("tie_we0", we, 4'b0001);
    check("tie_wdata0", wdata, 32'h0000FF00);
    step(1);
    check("tie_ack0", ack0, 1);
    req0 = 1'b0;
    step(2);
    check("tie_we1", we, 4'b1000);
    check("tie_wdata1", wdata, 32'h000000FF);
    step(1);
    check("tie_ack1", ack1, 1);
    req1 = 1'b0;
    step(1);
    check("tie_count", wr_count, 2);

    // Fairness: both requesters re-request right after each ack
    ack_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          idx0 = 2'(i); data0 = 24'h100000 + 24'(i); req0 = 1'b1;
          wait_ack(0);
          req0 = 1'b0;
          step(1);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          idx1 = 2'(3 - j); data1 = 24'h200000 + 24'(j); req1 = 1'b1;
          wait_ack(1);
          req1 = 1'b0;
          step(1);
        end
      end
    join
    check("fair_len", ack_log.size(), 8);
    for (int i = 0; i < ack_log.size(); i++) check("fair_order", ack_log[i], i % 2);
    check("fair_count", wr_count, 10);

    // Lock holds off a pending request
    lock = 1'b1; idx1 = 2'd1; data1 = 24'h00ABCD; req1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("lock_we", we, 4'b0000);
      check("lock_ack1", ack1, 0);
      check("lock_busy", busy, 0);
    end
    lock = 1'b0;
    step(1);
    check("unlock_we", we, 4'b0010);
    check("unlock_wdata", wdata, 32'h0000ABCD);
    step(1);
    check("unlock_ack1", ack1, 1);
    req1 = 1'b0;
    step(1);
    check("unlock_count", wr_count, 11);

    // Lock raised during WRITE does not stop the write
    idx0 = 2'd3; data0 = 24'h123456; req0 = 1'b1;
    step(1);
    check("lockw_we", we, 4'b1000);
    lock = 1'b1;
    step(1);
    check("lockw_ack0", ack0, 1);
    req0 = 1'b0;
    step(1);
    check("lockw_count", wr_count, 12);
    lock = 1'b0;
    step(1);

    // Reset in the WRITE cycle aborts the transaction
    do_reset();
    check("abort_pre_count", wr_count, 0);
    idx0 = 2'd2; data0 = 24'hC0FFEE; req0 = 1'b1;
    step(1);
    check("abort_we", we, 4'b0100);
    reset = 1'b1;
    step(1);
    check("abort_we_off", we, 4'b0000);
    check("abort_wdata_off", wdata, 0);
    check("abort_ack0", ack0, 0);
    check("abort_busy", busy, 0);
    check("abort_count", wr_count, 0);
    reset = 1'b0;
    step(1);
    check("retry_we", we, 4'b0100);
    check("retry_wdata", wdata, 32'h00C0FFEE);
    step(1);
    check("retry_ack0", ack0, 1);
    req0 = 1'b0;
    step(1);
    check("retry_count", wr_count, 1);

    // Counter wrap after 256 writes
    do_reset();
    for (int i = 0; i < 256; i++) begin
      idx0 = 2'(i); data0 = 24'(i * 3); req0 = 1'b1;
      wait_ack(0);
      req0 = 1'b0;
      step(1);
      if (i == 254) check("wrap_255", wr_count, 255);
    end
    check("wrap_zero", wr_count, 0);

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
